vote_session_ctrl: RTL and testbench

- Booth-level sequencer that sits in front of the vote logging counter.
- Accepts one voter authorization from the polling officer and turns the first clean candidate-button press into a single one-cycle candX_vote_valid pulse. It then locks the booth for a hold period before returning to idle.
- Rejects held buttons, multi-button presses and stale authorizations.
- Suppresses all voting while the system is in result mode.

---
 rtl/vote_session_ctrl_if.sv | 28 ++
 rtl/vote_session_ctrl.sv | 124 ++++++++++++
 tb/tb_vote_session_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vote_session_ctrl_if.sv
// rtl/vote_session_ctrl_if.sv - booth control/status bundle between officer panel and sequencer
interface vote_session_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             mode;
  logic             authorize;
  logic [3:0]       button;
  logic             cand1_vote_valid;
  logic             cand2_vote_valid;
  logic             cand3_vote_valid;
  logic             cand4_vote_valid;
  logic             booth_ready;
  logic             booth_busy;
  logic [CNT_W-1:0] total_votes;
  logic [CNT_W-1:0] spoiled_cnt;

  modport master (
    output mode, authorize, button,
    input  cand1_vote_valid, cand2_vote_valid, cand3_vote_valid, cand4_vote_valid,
    input  booth_ready, booth_busy, total_votes, spoiled_cnt
  );

  modport slave (
    input  mode, authorize, button,
    output cand1_vote_valid, cand2_vote_valid, cand3_vote_valid, cand4_vote_valid,
    output booth_ready, booth_busy, total_votes, spoiled_cnt
  );
endinterface

// File: rtl/vote_session_ctrl.sv
// rtl/vote_session_ctrl.sv - booth sequencer turning one authorized clean press into one vote pulse
module vote_session_ctrl #(
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 8
) (
  input  logic               clock,
  input  logic               reset,
  vote_session_ctrl_if.slave bus
);

  // One timer serves both the ARMED timeout and the HOLD lockout.
  localparam int TMAX = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_CAST  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             auth_q;
  logic [3:0]       button_q;
  logic [TW-1:0]    timer_q, timer_d;
  logic [3:0]       vote_q, vote_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] spoiled_q, spoiled_d;

  logic       auth_rise;
  logic [3:0] press;
  logic       button_onehot;
  logic       cast_fire;

  assign auth_rise     = bus.authorize & ~auth_q;
  assign press         = bus.button & ~button_q;
  assign button_onehot = (bus.button != 4'b0000) && ((bus.button & (bus.button - 4'd1)) == 4'b0000);

  // Result mode in the CAST cycle silently swallows the pending vote.
  assign cast_fire = (state_q == S_CAST) && !bus.mode;

  assign bus.cand1_vote_valid = cast_fire & vote_q[0];
  assign bus.cand2_vote_valid = cast_fire & vote_q[1];
  assign bus.cand3_vote_valid = cast_fire & vote_q[2];
  assign bus.cand4_vote_valid = cast_fire & vote_q[3];
  assign bus.booth_ready      = (state_q == S_ARMED);
  assign bus.booth_busy       = (state_q == S_CAST) || (state_q == S_HOLD);
  assign bus.total_votes      = total_q;
  assign bus.spoiled_cnt      = spoiled_q;

  // Next-state, timer and counter decisions for the booth session.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    vote_d    = vote_q;
    total_d   = total_q;
    spoiled_d = spoiled_q;
    case (state_q)
      S_IDLE: begin
        if (auth_rise && !bus.mode && (bus.button == 4'b0000)) begin
          state_d = S_ARMED;
          timer_d = '0;
        end
      end
      S_ARMED: begin
        if (bus.mode) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (press != 4'b0000) begin
          timer_d = '0;
          if (button_onehot) begin
            vote_d  = bus.button;
            state_d = S_CAST;
          end else begin
            if (spoiled_q != '1) spoiled_d = spoiled_q + CNT_W'(1);
            state_d = S_HOLD;
          end
        end else if (timer_q == TO_LAST) begin
          if (spoiled_q != '1) spoiled_d = spoiled_q + CNT_W'(1);
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_CAST: begin
        if (!bus.mode) total_d = total_q + CNT_W'(1);
        state_d = S_HOLD;
        timer_d = '0;
      end
      default: begin
        if (timer_q == HOLD_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
    endcase
  end

  // State, counters and edge-detect history; reset wipes any in-flight vote.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      auth_q    <= 1'b0;
      button_q  <= 4'b0000;
      timer_q   <= '0;
      vote_q    <= 4'b0000;
      total_q   <= '0;
      spoiled_q <= '0;
    end else begin
      state_q   <= state_d;
      auth_q    <= bus.authorize;
      button_q  <= bus.button;
      timer_q   <= timer_d;
      vote_q    <= vote_d;
      total_q   <= total_d;
      spoiled_q <= spoiled_d;
    end
  end

endmodule

// File: tb/tb_vote_session_ctrl.sv
// tb/tb_vote_session_ctrl.sv - scoreboard bench for vote_session_ctrl against a ballot-level model
module tb_vote_session_ctrl;
  localparam int HOLD  = 4;
  localparam int TOUT  = 1000;
  localparam int CW    = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  vote_session_ctrl_if #(.CNT_W(CW)) vif ();

  vote_session_ctrl #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TOUT), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (vif.slave)
  );

  typedef struct {
    int     cand;
    longint cyc;
  } vote_t;

  vote_t  exp_q[$];
  int     checks   = 0;
  int     failures = 0;

  // Ballot-level reference state
  longint cyc_m      = 0;
  bit     armed      = 0;
  int     armed_age  = 0;
  int     cast_cand  = 0;
  int     hold_left  = 0;
  int     exp_total  = 0;
  int     exp_spoil  = 0;
  bit     prev_a     = 0;
  bit [3:0] prev_b   = 0;

  // Reference model: advances once per clock, learns ballot outcomes from the rules
  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        armed = 0; armed_age = 0; cast_cand = 0; hold_left = 0;
        exp_total = 0; exp_spoil = 0; prev_a = 0; prev_b = 0;
        exp_q.delete();
      end else begin
        bit       a, m;
        bit [3:0] b, pr;
        a  = vif.authorize;
        m  = vif.mode;
        b  = vif.button;
        pr = b & ~prev_b;
        if (cast_cand != 0) begin
          if (!m) exp_total = (exp_total + 1) % (1 << CW);
          if (exp_q.size() > 0 && exp_q[0].cyc == cyc_m) begin
            if (!m) begin
              checks++;
              failures++;
              $display("FAIL missing_pulse cyc=%0d got none required cand%0d", cyc_m, exp_q[0].cand);
            end
            void'(exp_q.pop_front());
          end
          cast_cand = 0;
          hold_left = HOLD;
        end else if (hold_left > 0) begin
          hold_left--;
        end else if (armed) begin
          if (m) begin
            armed = 0;
          end else if (pr != 0) begin
            armed = 0;
            if ($countones(b) == 1) begin
              vote_t v;
              for (int k = 0; k < 4; k++) if (b[k]) cast_cand = k + 1;
              v.cand = cast_cand;
              v.cyc  = cyc_m + 1;
              exp_q.push_back(v);
            end else begin
              if (exp_spoil < (1 << CW) - 1) exp_spoil++;
              hold_left = HOLD;
            end
          end else if (armed_age == TOUT - 1) begin
            if (exp_spoil < (1 << CW) - 1) exp_spoil++;
            armed = 0;
          end else begin
            armed_age++;
          end
        end else begin
          if (a && !prev_a && !m && b == 4'b0000) begin
            armed = 1;
            armed_age = 0;
          end
        end
        prev_a = a;
        prev_b = b;
        cyc_m++;
      end
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard on each vote pulse
  initial begin
    forever begin
      @(negedge clock);
      begin
        bit [3:0] pul;
        bit       e_busy;
        pul    = {vif.cand4_vote_valid, vif.cand3_vote_valid, vif.cand2_vote_valid, vif.cand1_vote_valid};
        e_busy = (cast_cand != 0) || (hold_left > 0);
        checks++;
        if (vif.booth_ready !== armed) begin
          failures++;
          $display("FAIL booth_ready cyc=%0d got %b required %b", cyc_m, vif.booth_ready, armed);
        end
        checks++;
        if (vif.booth_busy !== e_busy) begin
          failures++;
          $display("FAIL booth_busy cyc=%0d got %b required %b", cyc_m, vif.booth_busy, e_busy);
        end
        checks++;
        if (vif.total_votes !== CW'(exp_total)) begin
          failures++;
          $display("FAIL total_votes cyc=%0d got %0d required %0d", cyc_m, vif.total_votes, exp_total);
        end
        checks++;
        if (vif.spoiled_cnt !== CW'(exp_spoil)) begin
          failures++;
          $display("FAIL spoiled_cnt cyc=%0d got %0d required %0d", cyc_m, vif.spoiled_cnt, exp_spoil);
        end
        if (pul !== 4'b0000) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse cyc=%0d got %b required none", cyc_m, pul);
          end else begin
            vote_t v;
            v = exp_q.pop_front();
            if (vif.mode || v.cyc != cyc_m || pul !== 4'(1 << (v.cand - 1))) begin
              failures++;
              $display("FAIL vote_pulse cyc=%0d mode=%b got %b required %b at cyc %0d",
                       cyc_m, vif.mode, pul, 4'(1 << (v.cand - 1)), v.cyc);
            end
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic auth_pulse();
    vif.authorize = 1'b1;
    step(1);
    vif.authorize = 1'b0;
  endtask

  task automatic check_now(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  initial begin
    int cands[5];
    cands = '{1, 2, 4, 4, 1};
    vif.mode      = 1'b0;
    vif.authorize = 1'b0;
    vif.button    = 4'b0000;
    step(3);
    check_now("reset_ready", int'(vif.booth_ready), 0);
    check_now("reset_busy", int'(vif.booth_busy), 0);
    check_now("reset_total", int'(vif.total_votes), 0);
    check_now("reset_spoil", int'(vif.spoiled_cnt), 0);
    reset = 1'b0;
    step(2);

    // Clean vote for candidate 3
    auth_pulse();
    step(3);
    check_now("ready_before_press", int'(vif.booth_ready), 1);
    vif.button = 4'b0100;
    step(1);
    vif.button = 4'b0000;
    step(8);
    check_now("total_after_c3", int'(vif.total_votes), 1);

    // Two buttons in one cycle spoil the ballot
    auth_pulse();
    vif.button = 4'b0011;
    step(1);
    vif.button = 4'b0000;
    step(8);
    check_now("spoil_after_multi", int'(vif.spoiled_cnt), 1);

    // Authorization while a button is held is ignored
    vif.button = 4'b0001;
    step(1);
    auth_pulse();
    step(2);
    check_now("held_auth_ignored", int'(vif.booth_ready), 0);
    vif.button = 4'b0000;
    step(2);

    // Timeout of an unused authorization
    auth_pulse();
    step(TOUT + 5);
    check_now("spoil_after_timeout", int'(vif.spoiled_cnt), 2);

    // Result mode cancels an armed booth
    auth_pulse();
    step(2);
    vif.mode = 1'b1;
    step(1);
    check_now("mode_cancels_arm", int'(vif.booth_ready), 0);
    vif.button = 4'b0010;
    step(1);
    vif.button = 4'b0000;
    step(3);
    vif.mode = 1'b0;
    step(2);

    // Five consecutive voters with extra presses during lockout
    foreach (cands[i]) begin
      auth_pulse();
      step(2);
      vif.button = 4'(1 << (cands[i] - 1));
      step(1);
      vif.button = 4'b0000;
      step(2);
      vif.button = 4'b1000;
      step(1);
      vif.button = 4'b0000;
      step(6);
    end
    check_now("total_after_five", int'(vif.total_votes), 6);

    // Asynchronous reset in the middle of HOLD
    auth_pulse();
    step(1);
    vif.button = 4'b0001;
    step(1);
    vif.button = 4'b0000;
    step(2);
    #2 reset = 1'b1;
    #1;
    check_now("async_reset_total", int'(vif.total_votes), 0);
    check_now("async_reset_busy", int'(vif.booth_busy), 0);
    step(1);
    reset = 1'b0;
    step(2);

    // Randomized sessions
    for (int c = 0; c < 5000; c++) begin
      int r;
      vif.authorize = ($urandom_range(0, 4) == 0);
      r = $urandom_range(0, 9);
      if (r < 6)       vif.button = 4'b0000;
      else if (r < 8)  vif.button = 4'(1 << $urandom_range(0, 3));
      else if (r == 8) vif.button = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) vif.mode = ~vif.mode;
      step(1);
    end
    vif.mode      = 1'b0;
    vif.authorize = 1'b0;
    vif.button    = 4'b0000;
    step(20);
    check_now("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
